ldst_mem_resp: RTL and testbench

- Memory-side responder for the load/store unit's request interface.
- Accepts single loads, single stores and fixed-length burst loads from the LSU.
- Owns the data RAM array and returns load data with a registered valid/last handshake.
- Sits between the LSU request port and the on-chip data memory, replacing a bare single-port RAM.

---
 rtl/ldst_mem_resp_if.sv | 27 ++
 rtl/ldst_mem_resp.sv | 145 ++++++++++++++
 tb/tb_ldst_mem_resp.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_mem_resp_if.sv
// Request/response bundle between the load/store unit (master) and the memory responder (slave).
interface ldst_mem_resp_if #(
    parameter int unsigned DAT_W  = 32,
    parameter int unsigned ADDR_W = 7
);
    logic              req_vld;
    logic              req_rdy;
    logic              req_we;
    logic              req_burst;
    logic [ADDR_W-1:0] req_addr;
    logic [DAT_W-1:0]  req_wdat;
    logic              rsp_vld;
    logic [DAT_W-1:0]  rsp_dat;
    logic              rsp_last;
    logic              busy;
    logic              perr;

    modport master (
        output req_vld, req_we, req_burst, req_addr, req_wdat,
        input  req_rdy, rsp_vld, rsp_dat, rsp_last, busy, perr
    );

    modport slave (
        input  req_vld, req_we, req_burst, req_addr, req_wdat,
        output req_rdy, rsp_vld, rsp_dat, rsp_last, busy, perr
    );
endinterface

// File: rtl/ldst_mem_resp.sv
// Memory-side responder for the LSU: owns the data RAM, serves stores, single and burst loads.
// Optional stored-parity checking is enabled by defining LDST_PARITY_EN.
module ldst_mem_resp #(
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    ldst_mem_resp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(BURST_LEN);
`ifdef LDST_PARITY_EN
    localparam int unsigned MEM_W = DAT_W + 1;
`else
    localparam int unsigned MEM_W = DAT_W;
`endif

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN - 1);

    if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("BURST_LEN must be in 2..16");
    end

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_last_q, rsp_last_d;
    logic [DAT_W-1:0]  rsp_dat_q, rsp_dat_d;

    logic [MEM_W-1:0]  mem_q [DEPTH];

    logic              accept;
    logic              wr_en;
    logic              beat;
    logic [ADDR_W-1:0] rd_addr;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;

    assign accept = bus.req_vld & (state_q == StIdle);
    assign wr_en  = accept & bus.req_we;

`ifdef LDST_PARITY_EN
    assign wr_word = {^bus.req_wdat, bus.req_wdat};
`else
    assign wr_word = bus.req_wdat;
`endif

    // Burst beats walk from the latched base; the ADDR_W-wide sum wraps past the top.
    assign rd_addr = (state_q == StBurst) ? base_q + ADDR_W'(cnt_q) : bus.req_addr;
    assign rd_word = mem_q[rd_addr];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.req_addr] <= wr_word;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        beat       = 1'b0;
        rsp_last_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && !bus.req_we) begin
                    beat = 1'b1;
                    if (bus.req_burst) begin
                        state_d = StBurst;
                        cnt_d   = CNT_W'(1);
                        base_d  = bus.req_addr;
                    end else begin
                        rsp_last_d = 1'b1;
                    end
                end
            end
            StBurst: begin
                beat = 1'b1;
                if (cnt_q == LastCnt) begin
                    rsp_last_d = 1'b1;
                    state_d    = StIdle;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign rsp_vld_d = beat;
    assign rsp_dat_d = beat ? rd_word[DAT_W-1:0] : rsp_dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_last_q <= 1'b0;
            rsp_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_last_q <= rsp_last_d;
            rsp_dat_q  <= rsp_dat_d;
        end
    end

`ifdef LDST_PARITY_EN
    logic perr_q, perr_d;

    // Even parity over data+stored bit is zero for a clean word; holds until the next beat.
    assign perr_d = beat ? ^rd_word : perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.req_rdy  = (state_q == StIdle);
    assign bus.busy     = (state_q == StBurst);
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_dat  = rsp_dat_q;
    assign bus.rsp_last = rsp_last_q;
endmodule

// File: tb/tb_ldst_mem_resp.sv
// Bench for ldst_mem_resp: table-driven single accesses plus hand-written burst/reset sequences,
// all load beats checked against a scoreboard queue filled when each request is driven.
module tb_ldst_mem_resp;
    localparam int unsigned DAT_W     = 32;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ldst_mem_resp_if #(.DAT_W(DAT_W), .ADDR_W(ADDR_W)) bus ();

    ldst_mem_resp #(
        .DAT_W    (DAT_W),
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DAT_W-1:0] dat;
        logic             last;
        logic             perr;
    } beat_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DAT_W-1:0]  wdat;
        logic [DAT_W-1:0]  exp;
    } vec_t;

    beat_t            sb[$];
    logic [DAT_W-1:0] model [DEPTH];
    int               n_vec = 0;
    int               n_err = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard consumer: every beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rsp_vld === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got rsp_dat %h, expected no beat at %0t",
                         bus.rsp_dat, $time);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("rsp_dat", bus.rsp_dat, e.dat);
                check("rsp_last", 32'(bus.rsp_last), 32'(e.last));
                check("perr", 32'(bus.perr), 32'(e.perr));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_vld = 1'b0;
    endtask

    // Presents a request and holds it until accepted; returns the number of not-ready edges.
    task automatic drive(input logic we, input logic burst, input logic [ADDR_W-1:0] addr,
                         input logic [DAT_W-1:0] wdat, input logic [DAT_W-1:0] exp_dat,
                         input logic exp_perr, output int waits);
        logic rdy;
        logic [ADDR_W-1:0] a;
        bus.req_vld   = 1'b1;
        bus.req_we    = we;
        bus.req_burst = burst;
        bus.req_addr  = addr;
        bus.req_wdat  = wdat;
        if (we) begin
            model[addr] = wdat;
        end else if (burst) begin
            for (int k = 0; k < BURST_LEN; k++) begin
                a = addr + ADDR_W'(k);
                sb.push_back('{dat: model[a], last: (k == BURST_LEN - 1), perr: 1'b0});
            end
        end else begin
            sb.push_back('{dat: exp_dat, last: 1'b1, perr: exp_perr});
        end
        waits = 0;
        rdy   = 1'b0;
        while (!rdy && waits < 50) begin
            @(negedge clk);
            rdy = bus.req_rdy;
            @(posedge clk);
            if (!rdy) waits++;
        end
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got req_rdy 0 for %0d cycles, expected accept", waits);
            bus.req_vld = 1'b0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        vec_t vt[11];
        int   w;
        int   w2;
        int   busy_cnt;
        int   rdy_low;
        int   vld_cnt;
        int   last_at;
        int   guard;

        vt[0]  = '{we: 1'b1, addr: 7'd3,   wdat: 32'h0f0f0f0f, exp: 32'h0};
        vt[1]  = '{we: 1'b1, addr: 7'd4,   wdat: 32'h0f0f0f0e, exp: 32'h0};
        vt[2]  = '{we: 1'b0, addr: 7'd3,   wdat: 32'h0,        exp: 32'h0f0f0f0f};
        vt[3]  = '{we: 1'b0, addr: 7'd4,   wdat: 32'h0,        exp: 32'h0f0f0f0e};
        vt[4]  = '{we: 1'b0, addr: 7'd0,   wdat: 32'h0,        exp: 32'h00000000};
        vt[5]  = '{we: 1'b0, addr: 7'd127, wdat: 32'h0,        exp: 32'h0000007f};
        vt[6]  = '{we: 1'b1, addr: 7'd127, wdat: 32'hdeadbeef, exp: 32'h0};
        vt[7]  = '{we: 1'b0, addr: 7'd127, wdat: 32'h0,        exp: 32'hdeadbeef};
        vt[8]  = '{we: 1'b0, addr: 7'd5,   wdat: 32'h0,        exp: 32'h00000005};
        vt[9]  = '{we: 1'b1, addr: 7'd2,   wdat: 32'h12345678, exp: 32'h0};
        vt[10] = '{we: 1'b0, addr: 7'd2,   wdat: 32'h0,        exp: 32'h12345678};

        bus.req_vld   = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdat  = '0;
        rst           = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("reset_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("reset_rsp_dat", bus.rsp_dat, 32'd0);
        check("reset_rsp_last", 32'(bus.rsp_last), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_perr", 32'(bus.perr), 32'd0);
        #2 rst = 1'b0;
        sync();

        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(i), DAT_W'(i), '0, 1'b0, w);
        end
        idle();

        // Single load: one-cycle latency, one beat only.
        sync();
        drive(1'b0, 1'b0, 7'd0, '0, 32'h0, 1'b0, w);
        idle();
        @(negedge clk);
        check("single_vld", 32'(bus.rsp_vld), 32'd1);
        check("single_last", 32'(bus.rsp_last), 32'd1);
        check("single_dat", bus.rsp_dat, 32'h0);
        @(negedge clk);
        check("single_vld_drop", 32'(bus.rsp_vld), 32'd0);
        sync();

        // Back-to-back table, including load immediately after store to the same address.
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].we, 1'b0, vt[i].addr, vt[i].wdat, vt[i].exp, 1'b0, w);
        end
        idle();
        repeat (2) sync();

        // Burst from 1: four beats, last on the fourth, busy/not-ready for three cycles.
        drive(1'b0, 1'b1, 7'd1, '0, '0, 1'b0, w);
        idle();
        busy_cnt = 0;
        rdy_low  = 0;
        vld_cnt  = 0;
        last_at  = -1;
        for (int c = 0; c < BURST_LEN; c++) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
            rdy_low  += int'(!bus.req_rdy);
            vld_cnt  += int'(bus.rsp_vld);
            if (bus.rsp_last && last_at < 0) last_at = c;
        end
        check("burst_busy_cycles", 32'(busy_cnt), 32'd3);
        check("burst_rdy_low_cycles", 32'(rdy_low), 32'd3);
        check("burst_beats", 32'(vld_cnt), 32'd4);
        check("burst_last_pos", 32'(last_at), 32'd3);
        @(negedge clk);
        check("burst_vld_drop", 32'(bus.rsp_vld), 32'd0);
        sync();

        // Wrapping burst with a load held behind it; accepted with no bubble.
        drive(1'b0, 1'b1, 7'd126, '0, '0, 1'b0, w);
        drive(1'b0, 1'b0, 7'd10, '0, model[10], 1'b0, w2);
        idle();
        check("held_req_waits", 32'(w2), 32'(BURST_LEN - 1));
        @(negedge clk);
        check("no_gap_vld", 32'(bus.rsp_vld), 32'd1);
        check("no_gap_last", 32'(bus.rsp_last), 32'd1);
        sync();
        sync();

        // Reset after the second beat of a burst aborts it.
        drive(1'b0, 1'b1, 7'd20, '0, '0, 1'b0, w);
        idle();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("abort_rsp_dat", bus.rsp_dat, 32'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        sync();
        drive(1'b0, 1'b0, 7'd3, '0, 32'h0f0f0f0f, 1'b0, w);
        idle();
        sync();

`ifdef LDST_PARITY_EN
        dut.mem_q[5][DAT_W] = ~dut.mem_q[5][DAT_W];
        drive(1'b0, 1'b0, 7'd5, '0, model[5], 1'b1, w);
        drive(1'b0, 1'b0, 7'd6, '0, model[6], 1'b0, w);
        idle();
        sync();
`endif

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            sync();
            guard++;
        end
        repeat (3) sync();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
